f1_reaction_timer: RTL and testbench

- Consumer of the F1 start-light sequence: watches the 8-bit light bar, detects lights-out, and measures the player's reaction time to a push-button in tick units (1 ms when driven from clktick).
- Sits beside the light-sequence FSM. Its `lights` input is that sequence's `data_out`, and its `tick` input comes from a clktick instance.
- Flags jump starts (press before lights-out) and time-outs.

---
 rtl/f1_reaction_timer.sv | 173 +++++++++++++++++
 tb/tb_f1_reaction_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: detects lights-out, times the button press in ticks,
// flags jump starts and time-outs. Define F1_REACTION_BEST_EN to track the best time.
module f1_reaction_timer #(
  parameter int WIDTH      = 16,
  parameter int TIMEOUT_MS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             tick,
  input  logic             button,
  output logic [WIDTH-1:0] reaction_ms,
  output logic             valid,
  output logic             false_start,
  output logic             timeout,
  output logic             busy,
  output logic [WIDTH-1:0] best_ms
);

  localparam logic [WIDTH-1:0] TIMEOUT_VAL  = WIDTH'(TIMEOUT_MS);
  localparam logic [WIDTH-1:0] TIMEOUT_LAST = WIDTH'(TIMEOUT_MS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARMED       = 3'd1,
    WAIT_OUT    = 3'd2,
    TIMING      = 3'd3,
    FALSE_START = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic [7:0]       lights_q, lights_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reaction_q, reaction_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             to_q, to_d;

  logic btn_rise;
  logic lights_out;

  assign btn_rise   = sync2_q & ~sync3_q;
  assign lights_out = (lights_q == 8'hFF) && (lights == 8'h00);

  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    lights_d = lights;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reaction_d = reaction_q;
    valid_d    = 1'b0;
    fs_d       = fs_q;
    to_d       = to_q;

    case (state_q)
      IDLE: begin
        if (lights != 8'h00) state_d = ARMED;
      end
      ARMED: begin
        if (btn_rise)                state_d = FALSE_START;
        else if (lights == 8'hFF)    state_d = WAIT_OUT;
        else if (lights == 8'h00)    state_d = IDLE;
      end
      WAIT_OUT: begin
        if (btn_rise) begin
          state_d = FALSE_START;
        end else if (lights_out) begin
          state_d = TIMING;
          count_d = '0;
        end else if (lights != 8'hFF && lights != 8'h00) begin
          state_d = ARMED;
        end
      end
      TIMING: begin
        // A press in the same cycle as a tick wins; that tick is dropped.
        if (btn_rise) begin
          reaction_d = count_q;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else if (lights != 8'h00) begin
          state_d = ARMED;
        end else if (tick) begin
          if (count_q == TIMEOUT_LAST) begin
            reaction_d = TIMEOUT_VAL;
            to_d       = 1'b1;
            valid_d    = 1'b1;
            state_d    = DONE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      FALSE_START: begin
        if (lights == 8'h00) state_d = IDLE;
      end
      DONE: begin
        if (lights != 8'h00) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == FALSE_START && state_q != FALSE_START) begin
      reaction_d = '0;
      fs_d       = 1'b1;
      valid_d    = 1'b1;
    end
    if (state_d == ARMED && state_q != ARMED) begin
      fs_d = 1'b0;
      to_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      lights_q   <= 8'h00;
      count_q    <= '0;
      reaction_q <= '0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      lights_q   <= lights_d;
      count_q    <= count_d;
      reaction_q <= reaction_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      to_q       <= to_d;
    end
  end

  assign reaction_ms = reaction_q;
  assign valid       = valid_q;
  assign false_start = fs_q;
  assign timeout     = to_q;
  assign busy        = (state_q == ARMED) || (state_q == WAIT_OUT) || (state_q == TIMING);

`ifdef F1_REACTION_BEST_EN
  logic [WIDTH-1:0] best_q, best_d;

  // Only a clean result strictly faster than the record replaces it.
  always_comb begin
    best_d = best_q;
    if (valid_d && !fs_d && !to_d && (reaction_d < best_q)) best_d = reaction_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) best_q <= '1;
    else      best_q <= best_d;
  end

  assign best_ms = best_q;
`else
  assign best_ms = '1;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: WIDTH=16, TIMEOUT_MS=50, one tick every 4 clocks.
module tb_f1_reaction_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  lights = 8'h00;
  logic        tick = 1'b0;
  logic        button = 1'b0;
  logic [15:0] reaction_ms;
  logic        valid;
  logic        false_start;
  logic        timeout;
  logic        busy;
  logic [15:0] best_ms;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;

  f1_reaction_timer #(.WIDTH(16), .TIMEOUT_MS(50)) dut (
    .clk(clk), .rst(rst), .lights(lights), .tick(tick), .button(button),
    .reaction_ms(reaction_ms), .valid(valid), .false_start(false_start),
    .timeout(timeout), .busy(busy), .best_ms(best_ms)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      tick = 1'b0;
      step(3);
      tick = 1'b1;
      step(1);
    end
    tick = 1'b0;
  endtask

  task automatic lights_up(input int k);
    logic [7:0] lv;
    lv = 8'h00;
    for (int i = 0; i < k; i++) begin
      lv = {lv[6:0], 1'b1};
      lights = lv;
      step(3);
    end
  endtask

  task automatic go_lights_out();
    lights_up(8);
    lights = 8'h00;
    step(1);
  endtask

  // Full run: lights-out, n ticks, press; returns at the expected valid cycle.
  task automatic do_run(input int n);
    go_lights_out();
    run_ticks(n);
    button = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (reaction_ms !== 16'd0) begin errors++; $display("FAIL reset_reaction got=%0d want=0", reaction_ms); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", valid); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%0b want=0", false_start); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (best_ms !== 16'hFFFF) begin errors++; $display("FAIL reset_best got=%0h want=ffff", best_ms); end
    step(2);
    rst = 1'b1;
    step(2);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int v0;
    v0 = valid_cnt;
    go_lights_out();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_timing got=%0b want=1", busy); end
    run_ticks(23);
    button = 1'b1;
    step(3);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b want=1", valid); end
    checks++; if (reaction_ms !== 16'd23) begin errors++; $display("FAIL basic_reaction got=%0d want=23", reaction_ms); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL basic_fs got=%0b want=0", false_start); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%0b want=0", timeout); end
    step(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%0b want=0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%0b want=0", busy); end
    button = 1'b0;
    step(3);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_pulse_count got=%0d want=1", valid_cnt - v0); end
    $display("test_basic reaction=%0d", reaction_ms);
  endtask

  task automatic test_false_start();
    int v0;
    lights_up(4);
    v0 = valid_cnt;
    button = 1'b1;
    step(3);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fs_valid got=%0b want=1", valid); end
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_flag got=%0b want=1", false_start); end
    checks++; if (reaction_ms !== 16'd0) begin errors++; $display("FAIL fs_reaction got=%0d want=0", reaction_ms); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy got=%0b want=0", busy); end
    button = 1'b0;
    step(3);
    button = 1'b1;
    step(4);
    button = 1'b0;
    step(3);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL fs_repress got=%0d want=1", valid_cnt - v0); end
    lights = 8'h00;
    step(2);
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_held got=%0b want=1", false_start); end
    lights = 8'h01;
    step(1);
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL fs_cleared got=%0b want=0", false_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_rearm_busy got=%0b want=1", busy); end
    lights = 8'h00;
    step(2);
    $display("test_false_start done");
  endtask

  task automatic test_timeout();
    int v0;
    go_lights_out();
    v0 = valid_cnt;
    run_ticks(49);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_early_valid got=%0b want=0", valid); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL to_early_count got=%0d want=0", valid_cnt - v0); end
    run_ticks(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL to_valid got=%0b want=1", valid); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%0b want=1", timeout); end
    checks++; if (reaction_ms !== 16'd50) begin errors++; $display("FAIL to_reaction got=%0d want=50", reaction_ms); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL to_fs got=%0b want=0", false_start); end
    step(1);
    button = 1'b1;
    step(4);
    button = 1'b0;
    step(3);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL to_late_press got=%0d want=1", valid_cnt - v0); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_held got=%0b want=1", timeout); end
    $display("test_timeout reaction=%0d", reaction_ms);
  endtask

  task automatic test_held_button();
    int v0;
    button = 1'b1;
    step(4);
    go_lights_out();
    v0 = valid_cnt;
    button = 1'b0;
    step(4);
    run_ticks(7);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL held_no_valid got=%0d want=0", valid_cnt - v0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy got=%0b want=1", busy); end
    button = 1'b1;
    step(3);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL held_valid got=%0b want=1", valid); end
    checks++; if (reaction_ms !== 16'd7) begin errors++; $display("FAIL held_reaction got=%0d want=7", reaction_ms); end
    button = 1'b0;
    step(3);
    $display("test_held_button reaction=%0d", reaction_ms);
  endtask

  task automatic test_press_on_tick();
    go_lights_out();
    run_ticks(12);
    button = 1'b1;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL tickpress_valid got=%0b want=1", valid); end
    checks++; if (reaction_ms !== 16'd12) begin errors++; $display("FAIL tickpress_reaction got=%0d want=12", reaction_ms); end
    button = 1'b0;
    step(3);
    $display("test_press_on_tick reaction=%0d", reaction_ms);
  endtask

  task automatic test_reset_mid_timing();
    int v0;
    go_lights_out();
    run_ticks(5);
    v0 = valid_cnt;
    rst = 1'b0;
    #1;
    checks++; if (reaction_ms !== 16'd0) begin errors++; $display("FAIL midrst_reaction got=%0d want=0", reaction_ms); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b want=0", valid); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL midrst_fs got=%0b want=0", false_start); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout got=%0b want=0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    checks++; if (best_ms !== 16'hFFFF) begin errors++; $display("FAIL midrst_best got=%0h want=ffff", best_ms); end
    step(3);
    rst = 1'b1;
    step(3);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d want=0", valid_cnt - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%0b want=0", busy); end
    $display("test_reset_mid_timing done");
  endtask

  task automatic test_best();
    logic [15:0] exp1, exp2, exp3;
`ifdef F1_REACTION_BEST_EN
    exp1 = 16'd30; exp2 = 16'd18; exp3 = 16'd18;
`else
    exp1 = 16'hFFFF; exp2 = 16'hFFFF; exp3 = 16'hFFFF;
`endif
    do_run(30);
    checks++; if (reaction_ms !== 16'd30) begin errors++; $display("FAIL best_run1_reaction got=%0d want=30", reaction_ms); end
    checks++; if (best_ms !== exp1) begin errors++; $display("FAIL best_run1 got=%0h want=%0h", best_ms, exp1); end
    button = 1'b0; step(3);
    do_run(18);
    checks++; if (best_ms !== exp2) begin errors++; $display("FAIL best_run2 got=%0h want=%0h", best_ms, exp2); end
    button = 1'b0; step(3);
    do_run(25);
    checks++; if (reaction_ms !== 16'd25) begin errors++; $display("FAIL best_run3_reaction got=%0d want=25", reaction_ms); end
    checks++; if (best_ms !== exp3) begin errors++; $display("FAIL best_run3 got=%0h want=%0h", best_ms, exp3); end
    button = 1'b0; step(3);
    lights_up(4);
    button = 1'b1;
    step(3);
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL best_fs_flag got=%0b want=1", false_start); end
    checks++; if (best_ms !== exp3) begin errors++; $display("FAIL best_after_fs got=%0h want=%0h", best_ms, exp3); end
    button = 1'b0;
    lights = 8'h00;
    step(3);
    $display("test_best best=%0h", best_ms);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_timeout();
    test_held_button();
    test_press_on_tick();
    test_reset_mid_timing();
    test_best();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
